// File: rtl/exec_mem_slice_pkg.sv
// exec_mem_slice_pkg: shared widths, register count and ALU op-codes for exec_mem_slice
package exec_mem_slice_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RAW   = $clog2(NREGS);
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;
endpackage

// File: rtl/gpr_file.sv
// gpr_file: 32 x 32-bit register file, r0 hardwired to zero, two combinational read ports
// Ports: clk/rst_n (async active-low clear), i_rd_addr_1/2 -> o_rd_data_1/2, i_wr_en/i_wr_addr/i_wr_data write port.
// Macro REGFILE_BYPASS_EN: reads of the register being written return i_wr_data instead of the old value.
module gpr_file
  import exec_mem_slice_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RAW-1:0]  i_rd_addr_1,
  input  logic [RAW-1:0]  i_rd_addr_2,
  input  logic [RAW-1:0]  i_wr_addr,
  input  logic            i_wr_en,
  input  logic [XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0] o_rd_data_1,
  output logic [XLEN-1:0] o_rd_data_2
);
  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_we;
  assign w_we = i_wr_en && (i_wr_addr != '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign o_rd_data_1 = (i_rd_addr_1 == '0) ? '0 : (w_we && i_wr_addr == i_rd_addr_1) ? i_wr_data : r_regs[i_rd_addr_1];
  assign o_rd_data_2 = (i_rd_addr_2 == '0) ? '0 : (w_we && i_wr_addr == i_rd_addr_2) ? i_wr_data : r_regs[i_rd_addr_2];
`else
  assign o_rd_data_1 = (i_rd_addr_1 == '0) ? '0 : r_regs[i_rd_addr_1];
  assign o_rd_data_2 = (i_rd_addr_2 == '0) ? '0 : r_regs[i_rd_addr_2];
`endif
endmodule

// File: rtl/exec_mem_slice.sv
// exec_mem_slice: register file + ALU + word-addressed data memory execute/memory slice
// Ports: clk/rst_n (async active-low clear of all state); register indices, write enable, ALU and memory
// controls in; register read data, alu_result, zero and mem_read_data out (all combinational).
// Macro REGFILE_BYPASS_EN: enables same-cycle write-to-read forwarding in gpr_file.
module exec_mem_slice
  import exec_mem_slice_pkg::*;
#(
  parameter int DMEM_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      reg_rd_addr_1,
  input  logic [4:0]      reg_rd_addr_2,
  input  logic [4:0]      reg_wr_addr,
  input  logic            reg_write_en,
  input  logic            alu_src,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      alu_control,
  input  logic            mem_write_en,
  input  logic            mem_read,
  input  logic            mem_to_reg,
  output logic [XLEN-1:0] reg_rd_data_1,
  output logic [XLEN-1:0] reg_rd_data_2,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [XLEN-1:0] mem_read_data
);
  localparam int AW = $clog2(DMEM_WORDS);
  logic [XLEN-1:0] r_dmem [DMEM_WORDS];
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_wb_data;
  logic [AW-1:0]   w_idx;
  gpr_file u_gpr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_addr_1 (reg_rd_addr_1),
    .i_rd_addr_2 (reg_rd_addr_2),
    .i_wr_addr   (reg_wr_addr),
    .i_wr_en     (reg_write_en),
    .i_wr_data   (w_wb_data),
    .o_rd_data_1 (reg_rd_data_1),
    .o_rd_data_2 (reg_rd_data_2)
  );
  assign w_op_b = alu_src ? imm : reg_rd_data_2;
  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = reg_rd_data_1 + w_op_b;
      ALU_SUB: alu_result = reg_rd_data_1 - w_op_b;
      ALU_AND: alu_result = reg_rd_data_1 & w_op_b;
      ALU_OR:  alu_result = reg_rd_data_1 | w_op_b;
      ALU_SLT: alu_result = {31'd0, $signed(reg_rd_data_1) < $signed(w_op_b)};
      ALU_XOR: alu_result = reg_rd_data_1 ^ w_op_b;
      ALU_SLL: alu_result = reg_rd_data_1 << w_op_b[4:0];
      ALU_SRL: alu_result = reg_rd_data_1 >> w_op_b[4:0];
      default: alu_result = '0;
    endcase
  end
  assign zero = (alu_result == '0);
  // byte address -> word index; low two bits and bits above the memory size are dropped so addresses wrap
  assign w_idx = alu_result[AW+1:2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) r_dmem[i] <= '0;
    end else if (mem_write_en) begin
      r_dmem[w_idx] <= reg_rd_data_2;
    end
  end
  assign mem_read_data = mem_read ? r_dmem[w_idx] : '0;
  assign w_wb_data = mem_to_reg ? mem_read_data : alu_result;
endmodule

// File: tb/tb_exec_mem_slice.sv
// tb_exec_mem_slice: directed stimulus with a scoreboard queue drained by a negedge monitor
module tb_exec_mem_slice;
  localparam int S_RD1 = 0, S_RD2 = 1, S_ALU = 2, S_ZERO = 3, S_MRD = 4;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [4:0]  reg_rd_addr_1 = 0, reg_rd_addr_2 = 0, reg_wr_addr = 0;
  logic        reg_write_en = 0, alu_src = 0, mem_write_en = 0, mem_read = 0, mem_to_reg = 0;
  logic [31:0] imm = 0;
  logic [2:0]  alu_control = 0;
  logic [31:0] reg_rd_data_1, reg_rd_data_2, alu_result, mem_read_data;
  logic        zero;
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  exec_mem_slice dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .reg_rd_addr_1 (reg_rd_addr_1),
    .reg_rd_addr_2 (reg_rd_addr_2),
    .reg_wr_addr   (reg_wr_addr),
    .reg_write_en  (reg_write_en),
    .alu_src       (alu_src),
    .imm           (imm),
    .alu_control   (alu_control),
    .mem_write_en  (mem_write_en),
    .mem_read      (mem_read),
    .mem_to_reg    (mem_to_reg),
    .reg_rd_data_1 (reg_rd_data_1),
    .reg_rd_data_2 (reg_rd_data_2),
    .alu_result    (alu_result),
    .zero          (zero),
    .mem_read_data (mem_read_data)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      act = (e.sel == S_RD1) ? reg_rd_data_1 : (e.sel == S_RD2) ? reg_rd_data_2 :
            (e.sel == S_ALU) ? alu_result : (e.sel == S_ZERO) ? {31'd0, zero} : mem_read_data;
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end
  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: wait expired after %0d checks", n_chk);
    $finish;
  end
  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] wa, input logic we,
                       input logic asrc, input logic [31:0] im, input logic [2:0] op,
                       input logic mw, input logic mr, input logic m2r);
    @(posedge clk);
    #1;
    reg_rd_addr_1 = a1; reg_rd_addr_2 = a2; reg_wr_addr = wa; reg_write_en = we;
    alu_src = asrc; imm = im; alu_control = op;
    mem_write_en = mw; mem_read = mr; mem_to_reg = m2r;
  endtask
  task automatic expect_v(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask
  task automatic wr_reg(input logic [4:0] rd, input logic [31:0] v);
    drive(0, 0, rd, 1, 1, v, 3'b000, 0, 0, 0);
    expect_v("wr_alu", S_ALU, v);
  endtask
  initial begin
    logic [31:0] bypass_exp;
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'd9;
`else
    bypass_exp = 32'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    mem_read = 1;
    #1;
    n_chk++;
    if (zero !== 1'b1 || mem_read_data !== 32'd0) begin
      n_fail++;
      $display("FAIL in_reset: zero=%b mem_read_data=%h", zero, mem_read_data);
    end
    mem_read = 0;
    rst_n = 1;
    drive(1, 31, 0, 0, 1, 32'd20, 3'b000, 0, 1, 0);
    expect_v("rst_r1", S_RD1, 0);
    expect_v("rst_r31", S_RD2, 0);
    expect_v("rst_mem5", S_MRD, 0);
    drive(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    expect_v("rst_zero", S_ZERO, 1);
    wr_reg(1, 7);
    drive(1, 0, 0, 0, 1, 7, 3'b001, 0, 0, 0);
    expect_v("r1", S_RD1, 7);
    expect_v("sub_alu", S_ALU, 0);
    expect_v("sub_zero", S_ZERO, 1);
    wr_reg(0, 32'h55);
    drive(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    expect_v("r0_still0", S_RD1, 0);
    expect_v("r0_zero", S_ZERO, 1);
    wr_reg(2, 32'hFFFF_FFFF);
    wr_reg(3, 32'h1);
    drive(2, 3, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    expect_v("add_wrap", S_ALU, 0);
    expect_v("add_zero", S_ZERO, 1);
    drive(2, 3, 0, 0, 0, 0, 3'b100, 0, 0, 0);
    expect_v("slt", S_ALU, 1);
    drive(3, 2, 0, 0, 0, 0, 3'b100, 0, 0, 0);
    expect_v("slt_rev", S_ALU, 0);
    drive(3, 2, 0, 0, 0, 0, 3'b001, 0, 0, 0);
    expect_v("sub", S_ALU, 2);
    drive(2, 3, 0, 0, 0, 0, 3'b010, 0, 0, 0);
    expect_v("and", S_ALU, 1);
    drive(2, 3, 0, 0, 0, 0, 3'b011, 0, 0, 0);
    expect_v("or", S_ALU, 32'hFFFF_FFFF);
    expect_v("or_zero", S_ZERO, 0);
    drive(2, 3, 0, 0, 0, 0, 3'b101, 0, 0, 0);
    expect_v("xor", S_ALU, 32'hFFFF_FFFE);
    drive(2, 0, 0, 0, 1, 4, 3'b111, 0, 0, 0);
    expect_v("srl", S_ALU, 32'h0FFF_FFFF);
    drive(3, 0, 0, 0, 1, 31, 3'b110, 0, 0, 0);
    expect_v("sll", S_ALU, 32'h8000_0000);
    drive(3, 0, 0, 0, 1, 32'h20, 3'b110, 0, 0, 0);
    expect_v("sll_b40", S_ALU, 1);
    wr_reg(4, 32'hDEAD_BEEF);
    drive(0, 4, 0, 0, 1, 32'h10, 3'b000, 1, 0, 0);
    expect_v("st_data", S_RD2, 32'hDEAD_BEEF);
    expect_v("st_mrd_off", S_MRD, 0);
    drive(0, 0, 6, 1, 1, 32'h13, 3'b000, 0, 1, 1);
    expect_v("ld_addr", S_ALU, 32'h13);
    expect_v("ld_data", S_MRD, 32'hDEAD_BEEF);
    drive(6, 0, 0, 0, 1, 32'h10, 3'b000, 0, 0, 0);
    expect_v("ld_rd", S_RD1, 32'hDEAD_BEEF);
    expect_v("mrd_off", S_MRD, 0);
    drive(0, 0, 0, 0, 1, 32'h410, 3'b000, 0, 1, 0);
    expect_v("mem_wrap", S_MRD, 32'hDEAD_BEEF);
    drive(0, 2, 0, 0, 1, 32'h10, 3'b000, 1, 1, 0);
    expect_v("rw_old", S_MRD, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 1, 32'h10, 3'b000, 0, 1, 0);
    expect_v("rw_new", S_MRD, 32'hFFFF_FFFF);
    drive(0, 5, 5, 1, 1, 9, 3'b000, 0, 0, 0);
    expect_v("same_cyc_r5", S_RD2, bypass_exp);
    drive(5, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    expect_v("r5_after", S_RD1, 9);
    drive(5, 1, 7, 1, 1, 32'h10, 3'b000, 1, 1, 0);
    rst_n = 0;
    expect_v("rstp_r5", S_RD1, 0);
    expect_v("rstp_r1", S_RD2, 0);
    expect_v("rstp_mem", S_MRD, 0);
    drive(5, 1, 7, 1, 1, 32'h10, 3'b000, 1, 1, 0);
    expect_v("rstp_hold", S_MRD, 0);
    drive(7, 0, 8, 1, 1, 32'h21, 3'b000, 0, 1, 0);
    rst_n = 1;
    expect_v("rst_no_wr_r7", S_RD1, 0);
    expect_v("rst_no_wr_mem", S_MRD, 0);
    drive(8, 4, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    expect_v("first_wr_r8", S_RD1, 32'h21);
    expect_v("rst_r4", S_RD2, 0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_mem_slice.md
EXEC_MEM_SLICE -- requirements
Module: exec_mem_slice

Interface
REQ-001 The block SHALL have one parameter: DMEM_WORDS, default 256, data-memory depth in 32-bit words (power of two, 4..1024).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, ports clk and rst_n.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- reg_rd_addr_1  in  5  source register A index
- reg_rd_addr_2  in  5  source register B index
- reg_wr_addr  in  5  destination register index
- reg_write_en  in  1  register write enable
- alu_src  in  1  1: ALU operand B = imm; 0: register B
- imm  in  32  sign-extended immediate
- alu_control  in  3  ALU operation select
- mem_write_en  in  1  data-memory write enable
- mem_read  in  1  data-memory read enable
- mem_to_reg  in  1  1: writeback = memory data; 0: ALU result
- reg_rd_data_1  out  32  register A contents
- reg_rd_data_2  out  32  register B contents
- alu_result  out  32  ALU result
- zero  out  1  alu_result == 0
- mem_read_data  out  32  data-memory read data

Function
REQ-004 The register file SHALL hold 32 x 32-bit registers; register 0 SHALL read 0 and ignore writes.
REQ-005 Register reads SHALL be combinational; a write SHALL occur on the rising clk edge when reg_write_en=1, storing the writeback value at reg_wr_addr.
REQ-006 The writeback value SHALL be mem_read_data when mem_to_reg=1, else alu_result.
REQ-007 A read of the register being written in the same cycle SHALL return the old value (the new value is visible after the edge) unless REGFILE_BYPASS_EN is defined.
REQ-008 ALU operand A SHALL be reg_rd_data_1; operand B SHALL be imm when alu_src=1, else reg_rd_data_2.
REQ-009 alu_control SHALL decode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed, result 1 or 0), 101 XOR, 110 SLL by B[4:0], 111 SRL (logical) by B[4:0].
REQ-010 ADD/SUB SHALL wrap modulo 2^32 with no overflow flag; zero SHALL be combinational from alu_result.
REQ-011 Data memory SHALL be DMEM_WORDS x 32-bit, word-indexed by alu_result[log2(DMEM_WORDS)+1:2]; bits [1:0] and the upper address bits SHALL be ignored, so addresses wrap modulo the memory size.
REQ-012 A memory write of reg_rd_data_2 SHALL occur on the rising clk edge when mem_write_en=1.
REQ-013 mem_read_data SHALL be the combinational word at the index when mem_read=1, else 0.
REQ-014 During a simultaneous read and write of the same word, mem_read_data SHALL show the old data until the edge.

Reset
REQ-015 While rst_n=0, all registers and all memory words SHALL clear to 0 asynchronously, and writes SHALL be suppressed.
REQ-016 After rst_n deasserts, the first write SHALL occur on the first rising edge.
REQ-017 All outputs are combinational; after reset they SHALL reflect all-zero state (e.g. zero=1 with ADD of r0,r0).

Configuration
REQ-018 When macro REGFILE_BYPASS_EN is defined, a read whose address equals a nonzero reg_wr_addr with reg_write_en=1 SHALL return the current writeback value; without it, REQ-007 old-value behaviour applies.

Structure
REQ-019 A shared package SHALL hold XLEN=32, the register count, and the ALU op-code constants from REQ-009.
REQ-020 The register file SHALL be a sub-module named gpr_file; the ALU and data memory SHALL be inline in exec_mem_slice.

Verification
REQ-021 Reset, then read r1 and r31, and memory word 5 with mem_read=1 -> all read 0.
REQ-022 Write r1=7 (imm=7, alu_src=1, ADD from r0, reg_write_en=1), then SUB r1 with imm 7 -> alu_result=0, zero=1; write to r0 -> r0 still 0.
REQ-023 r2=0xFFFFFFFF, r3=1: ADD -> 0; SLT r2,r3 -> 1; SRL r2 by 4 -> 0x0FFFFFFF; SLL r3 by 31 -> 0x80000000.
REQ-024 With r4=0xDEADBEEF, store at address 0x10 (ADD r0+imm 0x10, mem_write_en=1) -> next cycle load at 0x13 with mem_read=1, mem_to_reg=1 returns 0xDEADBEEF into rd; with mem_read=0, mem_read_data=0.
REQ-025 Same-cycle write r5=9 while reading r5 -> old value without REGFILE_BYPASS_EN, 9 with it; rst_n pulsed mid-sequence -> all state 0 immediately.
